muldiv_unit: RTL and testbench

Iterative multiply/divide responder with architectural HI/LO registers for the single-cycle MIPS core. The datapath issues `mult`/`multu`/`div`/`divu` requests and `mthi`/`mtlo` writes, and reads results back for `mfhi`/`mflo`. The unit computes one bit per cycle and reports progress with `busy`/`done`. The core stalls on `busy` before any HI/LO read.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU:   r = 1'b1;
            OP_MULT, OP_MULTU: r = 1'b0;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        logic r;
        case (op)
            OP_MULT, OP_DIV:   r = 1'b1;
            OP_MULTU, OP_DIVU: r = 1'b0;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on the packed
// {upper, lower} accumulator; the divide quotient bit is returned separately.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 qbit_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q;

    // Next accumulator: multiplier bit in acc_i[0], or dividend MSB shifted into the remainder
    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};
        q       = 1'b0;
        acc_o   = acc_i;
        if (is_div_i) begin
            // remainder < divisor keeps shifted < 2*divisor, so diff[WIDTH] is a clean borrow
            q = ~diff[WIDTH];
            if (q) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
            end
        end
        qbit_o = q;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu engine with architectural HI/LO registers;
// one bit per cycle, sign correction and HI/LO write in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_div_q;
    logic                 sign_a_q;
    logic                 neg_q;
    logic                 bzero_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     a_raw_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;

    logic                 start_div;
    logic                 start_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   step_acc;
    logic                 step_qbit;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;
    logic                 dbz_d;

    // Request decode and operand magnitudes for the accepting edge
    always_comb begin
        start_div    = op_is_div(op_i);
        start_signed = op_is_signed(op_i);
        a_neg        = start_signed & a_i[WIDTH-1];
        b_neg        = start_signed & b_i[WIDTH-1];
        a_mag        = a_neg ? (~a_i + WIDTH'(1)) : a_i;
        b_mag        = b_neg ? (~b_i + WIDTH'(1)) : b_i;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .qbit_o   (step_qbit)
    );

    // Sign-corrected result; divide by zero reports all-ones quotient and the raw dividend
    always_comb begin
        acc_d    = {step_acc[2*WIDTH-1:1], step_acc[0] | step_qbit};
        prod_fix = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        quot_fix = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];
        dbz_d    = is_div_q & bzero_q;
        if (is_div_q) begin
            if (bzero_q) begin
                hi_d = a_raw_q;
                lo_d = {WIDTH{1'b1}};
            end else begin
                hi_d = rem_fix;
                lo_d = quot_fix;
            end
        end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end
    end

    // Control FSM, iteration counter and HI/LO architectural state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            opnd_q   <= {WIDTH{1'b0}};
            a_raw_q  <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    dbz_q  <= 1'b0;
                    if (start_i) begin
                        is_div_q <= start_div;
                        sign_a_q <= a_neg;
                        neg_q    <= a_neg ^ b_neg;
                        bzero_q  <= (b_i == {WIDTH{1'b0}});
                        a_raw_q  <= a_i;
                        opnd_q   <= start_div ? b_mag : a_mag;
                        acc_q    <= {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
                        cnt_q    <= {CW{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end else begin
                        if (wr_hi_i) begin
                            hi_q <= wdata_i;
                        end
                        if (wr_lo_i) begin
                            lo_q <= wdata_i;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    dbz_q   <= dbz_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= {CW{1'b0}};
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .wr_hi_i       (wr_hi),
        .wr_lo_i       (wr_lo),
        .wdata_i       (wdata),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz),
        .hi_o          (hi),
        .lo_o          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the MIPS definitions
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        rdbz = 1'b0;
        rhi  = 32'd0;
        rlo  = 32'd0;
        case (o)
            2'b00: begin p = 64'(sx * sy); rhi = p[63:32]; rlo = p[31:0]; end
            2'b01: begin p = {32'd0, x} * {32'd0, y}; rhi = p[63:32]; rlo = p[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    rhi = x; rlo = 32'hFFFF_FFFF; rdbz = 1'b1;
                end else if (o == 2'b10) begin
                    rlo = 32'(sx / sy); rhi = 32'(sx % sy);
                end else begin
                    rlo = x / y; rhi = x % y;
                end
            end
        endcase
    endfunction

    // Issue one op, scramble the operand inputs after acceptance, wait for done
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit now, output int lat, output int bcnt);
        if (!now) @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t        vecs[10];
        int          lat;
        int          bc;
        int          k;
        int          pulses;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{2'b11, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
        vecs[7] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};

        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bc);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
            check($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_done_clr", i), 64'(done), 64'd0);
            check($sformatf("vec%0d_dbz_clr", i), 64'(dbz), 64'd0);
        end

        // start and mtlo during CALC are ignored
        @(negedge clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h1234; b = 32'h99; wr_lo = 1'b1; wdata = 32'h55;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("midop_lat", 64'(5 + k), 64'd33);
        check("midop_lo", 64'(lo), 64'd14);
        check("midop_hi", 64'(hi), 64'd2);

        // mthi + mtlo together in IDLE
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_ABCD;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("mthilo_hi", 64'(hi), 64'h0000_ABCD);
        check("mthilo_lo", 64'(lo), 64'h0000_ABCD);

        // start and mthi in the same IDLE cycle: write dropped
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; wr_hi = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        check("startwins_busy", 64'(busy), 64'd1);
        check("startwins_hi_stale", 64'(hi), 64'h0000_ABCD);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("startwins_hi", 64'(hi), 64'd0);
        check("startwins_lo", 64'(lo), 64'd6);

        // reset aborts a multiply mid-flight
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1357_9BDF;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, bc);
        check("after_abort_lat", 64'(lat), 64'd33);
        check("after_abort_hi", 64'(hi), 64'hFFFF_FFFF);
        check("after_abort_lo", 64'(lo), 64'hFFFF_FFF1);

        // back-to-back: new start in the done cycle
        run_op(2'b11, 32'd100, 32'd7, 1'b0, lat, bc);
        check("b2b_first_lo", 64'(lo), 64'd14);
        run_op(2'b01, 32'd7, 32'd9, 1'b1, lat, bc);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_lo", 64'(lo), 64'd63);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = 32'hFFFF_FFFF;
                default: ry = 32'($urandom);
            endcase
            model(ro, rx, ry, ehi, elo, edbz);
            run_op(ro, rx, ry, 1'b0, lat, bc);
            check($sformatf("rnd%0d_op%0d_hi", i, ro), 64'(hi), 64'(ehi));
            check($sformatf("rnd%0d_op%0d_lo", i, ro), 64'(lo), 64'(elo));
            check($sformatf("rnd%0d_op%0d_dbz", i, ro), 64'(dbz), 64'(edbz));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
